// File: rtl/bus_reader.sv
// Round-robin arbiter and sampler for the shared count bus.
// Grants one source at a time and checks each source's samples count up by one.
module bus_reader #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             run,
    input  logic [N_SRC-1:0] src_mask,
    input  logic [WIDTH-1:0] bus,
    output logic [N_SRC-1:0] en,
    output logic             smp_valid,
    output logic [WIDTH-1:0] smp_data,
    output logic [2:0]       smp_src,
    output logic             err,
    output logic [WIDTH-1:0] err_exp,
    output logic [7:0]       err_cnt
);

    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   sel, sel_n;
    logic [IW-1:0]   pick;
    logic [3:0]      dwell, dwell_n;
    logic            start;
    logic [WIDTH-1:0] last [N_SRC];
    logic [N_SRC-1:0] seen;
    logic [WIDTH-1:0] expv;

    // First unmasked source at or after the pointer, wrapping at N_SRC.
    always_comb begin
        logic          found;
        int unsigned   j;
        logic [IW-1:0] jj;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            j  = (32'(ptr) + k) % N_SRC;
            jj = IW'(j);
            if (!found && src_mask[jj]) begin
                pick  = jj;
                found = 1'b1;
            end
        end
    end

    assign start = run && (src_mask != '0);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            dwell <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            dwell <= dwell_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        dwell_n = dwell;
        en      = '0;
        unique case (state)
            IDLE, GAP: begin
                if (start) begin
                    state_n = GRANT;
                    sel_n   = pick;
                    dwell_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                en[sel] = 1'b1;
                if (dwell == 4'(DWELL - 1)) begin
                    state_n = GAP;
                    ptr_n   = (sel == IW'(N_SRC - 1)) ? '0 : sel + 1'b1;
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign expv = last[sel] + 1'b1;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_src   <= '0;
            err       <= 1'b0;
            err_exp   <= '0;
            err_cnt   <= '0;
            seen      <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) last[i] <= '0;
        end else begin
            smp_valid <= 1'b0;
            err       <= 1'b0;
            if (state == GRANT) begin
                smp_valid <= 1'b1;
                smp_data  <= bus;
                smp_src   <= 3'(sel);
                seen[sel] <= 1'b1;
                // Always resync to the bus so a single bad value flags once.
                last[sel] <= bus;
                if (seen[sel] && bus != expv) begin
                    err     <= 1'b1;
                    err_exp <= expv;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bus_reader.md
Name: bus_reader

Overview:
- Consumer and arbiter on the far side of the shared tri-state count bus.
- Grants bus ownership to one of N_SRC counter-generator sources at a time by driving their enables one-hot in round-robin order.
- Samples the value the granted source drives and checks per-source continuity: each sample must equal that source's previous sample + 1, modulo 2^WIDTH.
- Reports samples and continuity errors to the bench or status logic.

Parameters:
- N_SRC, 4, number of sources on the shared bus (2..8).
- WIDTH, 8, bus and counter width.
- DWELL, 4, consecutive cycles each grant lasts (1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- res  in  1  asynchronous reset, active-high.
- run  in  1  1 = arbitrate and sample; 0 = stop after the current grant completes.
- src_mask  in  N_SRC  1 = source participates; masked sources are skipped.
- bus  in  WIDTH  shared tri-state bus, driven by the granted source.
- en  out  N_SRC  one-hot grant / enable to the sources; all zero when no grant.
- smp_valid  out  1  one-cycle pulse: smp_data / smp_src hold a new sample.
- smp_data  out  WIDTH  sampled bus value.
- smp_src  out  3  index of the source that produced the sample.
- err  out  1  one-cycle pulse: continuity mismatch on this sample.
- err_exp  out  WIDTH  expected value at the last error.
- err_cnt  out  8  total errors since reset; saturates at 255.

Behaviour:
- Reset:
  - Applied asynchronously, active-high: en=0 immediately, regardless of clk.
  - All outputs 0. FSM to IDLE.
  - Round-robin pointer resets so the next grant goes to source 0 (or the first unmasked source).
  - Every per-source "seen" flag cleared.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: en=0. If run=1 and src_mask!=0, select the next unmasked source at or after the pointer and go to GRANT; otherwise stay in IDLE.
  - GRANT: en has exactly the selected bit set for exactly DWELL cycles (dwell counter counts 0..DWELL-1). At the end, go to GAP and advance the pointer past the granted source, wrapping at N_SRC.
  - GAP: exactly one cycle with en=0 (bus turnaround; the bus floats). Then, if run=1 and src_mask!=0, go directly to GRANT for the next unmasked source; otherwise go to IDLE.
- run and src_mask changes:
  - run falling during GRANT never truncates the grant.
  - src_mask is evaluated only when a source is selected (leaving IDLE or GAP). A mask change mid-grant does not truncate the grant.
- Sampling and latency:
  - The source drives the bus combinationally while enabled, so the bus value is valid in the same cycle en is high.
  - Each cycle in GRANT, the bus is captured at the closing clock edge.
  - smp_valid, smp_data and smp_src are registered and appear 1 cycle later: one sample per grant cycle, DWELL samples per grant.
  - No sample is taken in IDLE or GAP.
- Continuity check:
  - Per-source register last[i] (WIDTH bits) plus flag seen[i].
  - If seen[i]=0: record the sample, set seen[i], no check.
  - Otherwise expected = last[i]+1, wrapping 2^WIDTH-1 -> 0.
  - On mismatch: err pulses together with smp_valid, err_exp = expected, err_cnt increments (saturating at 255).
  - last[i] is always updated to the sampled value, so one bad value produces one error, not a cascade.
  - Continuity spans grants: a source holds its counter while not enabled.
- Wrap-around: 0xFF followed by 0x00 (WIDTH=8) is valid, not an error.
- Pointer rule: with a single unmasked source, that source is re-granted after every GAP.
- Reset mid-GRANT: en drops asynchronously, and any in-flight sample is discarded (smp_valid=0).

Test Plan:
- Reset, then run=1, src_mask=4'b0011, two generators starting at 0, DWELL=4:
  - en sequence is 0001 x4, 0000, 0010 x4, 0000, repeating.
  - Source 0 samples: 0,1,2,3, then 4,5,6,7.
  - No err; err_cnt=0.
- Latency: en[0] rises at cycle t with bus=0x05 -> smp_valid=1, smp_data=0x05, smp_src=0 at cycle t+1.
- Wrap: source preloaded to 0xFE -> samples 0xFE, 0xFF, 0x00, 0x01; no err.
- Fault: bench forces bus=0x09 when 0x06 is expected:
  - err=1, err_exp=0x06, err_cnt=1.
  - Next sample 0x0A gives no error.
- Stop and mask:
  - run dropped in the 2nd grant cycle -> the grant still lasts 4 cycles, then GAP, then IDLE with en=0.
  - src_mask=4'b0100 -> only en[2] is granted, separated by GAP cycles.
- Async reset:
  - Assert res mid-GRANT between clock edges -> en=0 immediately, outputs 0.
  - After release, the first grant goes to source 0 and its first sample is not checked.
